// File: rtl/core_acc.sv
// core_acc: accumulates N signed partial sums into one result and queues it in a 2-entry FIFO.
// Define CORE_ACC_SAT_EN for saturating additions; the default build wraps modulo 2^ODATA_BIT.
module core_acc #(
  parameter int IDATA_BIT = 22,
  parameter int ODATA_BIT = 32,
  parameter int CNT_BIT   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic [CNT_BIT-1:0]   cfg_acc_num,
  input  logic [IDATA_BIT-1:0] idata,
  input  logic                 idata_valid,
  output logic [ODATA_BIT-1:0] odata,
  output logic                 odata_valid,
  input  logic                 odata_ready,
  output logic                 busy,
  output logic                 err_ovf
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  localparam logic signed [ODATA_BIT-1:0] MAXV =
    {1'b0, {(ODATA_BIT-1){1'b1}}};
  localparam logic signed [ODATA_BIT-1:0] MINV =
    {1'b1, {(ODATA_BIT-1){1'b0}}};

  state_t                      r_state;
  logic        [CNT_BIT-1:0]   r_cnt;
  logic        [CNT_BIT-1:0]   r_n;
  logic signed [ODATA_BIT-1:0] r_acc;
  logic                        r_done;
  logic signed [ODATA_BIT-1:0] r_res;

  logic        [ODATA_BIT-1:0] r_mem [2];
  logic                        r_rd;
  logic        [1:0]           r_fcnt;
  logic                        r_err;

  logic signed [ODATA_BIT-1:0] w_ext;
  logic signed [ODATA_BIT:0]   w_sum;
  logic signed [ODATA_BIT-1:0] w_acc_nxt;
  logic        [CNT_BIT-1:0]   w_n;
  logic        [CNT_BIT-1:0]   w_cnt_nxt;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_push_ok;
  logic                        w_wr;

  assign w_ext = ODATA_BIT'($signed(idata));
  assign w_sum = (ODATA_BIT+1)'(r_acc) + (ODATA_BIT+1)'(w_ext);
  assign w_n   = (cfg_acc_num == '0) ? CNT_BIT'(1) : cfg_acc_num;
  assign w_cnt_nxt = r_cnt + CNT_BIT'(1);

`ifdef CORE_ACC_SAT_EN
  // Clamp when the extra top bit disagrees with the result sign bit.
  always_comb begin
    w_acc_nxt = w_sum[ODATA_BIT-1:0];
    if (w_sum[ODATA_BIT] != w_sum[ODATA_BIT-1])
      w_acc_nxt = w_sum[ODATA_BIT] ? MINV : MAXV;
  end
`else
  // Two's complement wrap: just drop the carry bit.
  always_comb begin
    w_acc_nxt = w_sum[ODATA_BIT-1:0];
  end
`endif

  // Accumulation FSM; completed results are staged one cycle before the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= CNT_BIT'(1);
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (idata_valid) begin
        unique case (r_state)
          S_IDLE: begin
            r_n   <= w_n;
            r_acc <= w_ext;
            if (w_n == CNT_BIT'(1)) begin
              r_done <= 1'b1;
              r_res  <= w_ext;
            end else begin
              r_cnt   <= CNT_BIT'(1);
              r_state <= S_ACC;
            end
          end
          S_ACC: begin
            r_acc <= w_acc_nxt;
            if (w_cnt_nxt == r_n) begin
              r_done  <= 1'b1;
              r_res   <= w_acc_nxt;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_pop     = (r_fcnt != 2'd0) && odata_ready;
  assign w_full    = (r_fcnt == 2'd2);
  assign w_push_ok = r_done && (!w_full || w_pop);
  // When full, rd ^ 0 == rd: the new entry lands in the slot being popped.
  assign w_wr      = r_rd ^ r_fcnt[0];

  // Two-entry output FIFO with sticky drop flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_fcnt   <= 2'd0;
      r_err    <= 1'b0;
    end else if (clr) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_fcnt   <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_push_ok)
        r_mem[w_wr] <= r_res;
      if (r_done && w_full && !w_pop)
        r_err <= 1'b1;
      if (w_pop)
        r_rd <= ~r_rd;
      r_fcnt <= r_fcnt + {1'b0, w_push_ok} - {1'b0, w_pop};
    end
  end

  assign odata       = r_mem[r_rd];
  assign odata_valid = (r_fcnt != 2'd0);
  assign busy        = (r_state == S_ACC);
  assign err_ovf     = r_err;

endmodule

// File: tb/tb_core_acc.sv
// tb_core_acc: directed checks of core_acc, default width plus a 22-bit output instance.
// Expected values for the narrow overflow case follow CORE_ACC_SAT_EN.
module tb_core_acc;

  logic               clk = 1'b0;
  logic               rstn;
  logic               clr;
  logic [7:0]         cfg;
  logic [21:0]        idata;
  logic               ivld;
  logic signed [31:0] odata;
  logic               ovld;
  logic               ordy;
  logic               busy;
  logic               err;

  logic [21:0]        n_idata;
  logic               n_ivld;
  logic signed [21:0] n_odata;
  logic               n_ovld;
  logic               n_busy;
  logic               n_err;

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  core_acc u_dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .cfg_acc_num(cfg), .idata(idata),
    .idata_valid(ivld), .odata(odata),
    .odata_valid(ovld), .odata_ready(ordy),
    .busy(busy), .err_ovf(err)
  );

  core_acc #(.IDATA_BIT(22), .ODATA_BIT(22)) u_nar (
    .clk(clk), .rstn(rstn), .clr(clr),
    .cfg_acc_num(cfg), .idata(n_idata),
    .idata_valid(n_ivld), .odata(n_odata),
    .odata_valid(n_ovld), .odata_ready(ordy),
    .busy(n_busy), .err_ovf(n_err)
  );

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    chks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [21:0] v);
    ivld  = 1'b1;
    idata = v;
    tick();
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; cfg = 8'd0;
    idata = '0; ivld = 1'b0; ordy = 1'b1;
    n_idata = '0; n_ivld = 1'b0;
    #12;
    chk("rst_odata", odata, 0);
    chk("rst_ovld", 32'(ovld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // four-beat sum
    cfg = 8'd4;
    beat(10);   chk("a_busy1", 32'(busy), 1);
    beat(-3);   chk("a_busy2", 32'(busy), 1);
    beat(7);    chk("a_busy3", 32'(busy), 1);
    beat(100);  chk("a_busy4", 32'(busy), 0);
    chk("a_lat", 32'(ovld), 0);
    ivld = 1'b0;
    tick();
    chk("a_ovld", 32'(ovld), 1);
    chk("a_sum", odata, 114);
    tick();
    chk("a_pop", 32'(ovld), 0);

    // length 0 acts as 1
    cfg = 8'd0;
    beat(5);    chk("b_busy1", 32'(busy), 0);
    beat(-5);   chk("b_busy2", 32'(busy), 0);
    chk("b_r1", odata, 5);
    ivld = 1'b0;
    tick();
    chk("b_r2", odata, -5);
    chk("b_ovld", 32'(ovld), 1);
    tick();
    chk("b_empty", 32'(ovld), 0);

    // overflow drop with ready low
    cfg = 8'd1; ordy = 1'b0;
    beat(1); beat(2); beat(3);
    ivld = 1'b0;
    tick();
    chk("c_err", 32'(err), 1);
    chk("c_h1", odata, 1);
    tick();
    chk("c_hold", odata, 1);
    chk("c_ovld", 32'(ovld), 1);
    ordy = 1'b1;
    tick();
    chk("c_h2", odata, 2);
    tick();
    chk("c_empty", 32'(ovld), 0);
    chk("c_sticky", 32'(err), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("c_clr", 32'(err), 0);

    // push and pop together while full
    ordy = 1'b0;
    beat(1); beat(2); beat(3);
    chk("d_h1", odata, 1);
    ivld = 1'b0; ordy = 1'b1;
    tick();
    chk("d_h2", odata, 2);
    chk("d_err", 32'(err), 0);
    tick();
    chk("d_h3", odata, 3);
    tick();
    chk("d_empty", 32'(ovld), 0);
    chk("d_err2", 32'(err), 0);

    // narrow instance: 22-bit overflow
    cfg = 8'd2;
    n_ivld = 1'b1; n_idata = 22'd2097151;
    tick();
    n_idata = 22'd1;
    tick();
    n_ivld = 1'b0;
    tick();
    chk("e_ovld", 32'(n_ovld), 1);
`ifdef CORE_ACC_SAT_EN
    chk("e_sum", n_odata, 2097151);
`else
    chk("e_sum", n_odata, -2097152);
`endif
    tick();

    // reset mid-accumulation
    cfg = 8'd4;
    beat(1); beat(1);
    chk("f_busy", 32'(busy), 1);
    ivld = 1'b0;
    rstn = 1'b0;
    #2;
    chk("f_rbusy", 32'(busy), 0);
    rstn = 1'b1;
    tick();
    beat(1); beat(1); beat(1); beat(1);
    ivld = 1'b0;
    tick();
    chk("f_sum", odata, 4);
    chk("f_err", 32'(err), 0);
    tick();

    // clr with a beat present
    beat(1); beat(1);
    clr = 1'b1; ivld = 1'b1; idata = 22'd7;
    tick();
    clr = 1'b0;
    chk("g_busy", 32'(busy), 0);
    beat(1); beat(1); beat(1); beat(1);
    ivld = 1'b0;
    tick();
    chk("g_sum", odata, 4);
    chk("g_ovld", 32'(ovld), 1);
    tick();
    chk("g_empty", 32'(ovld), 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
